// File: rtl/amm_mem_responder_if.sv
// rtl/amm_mem_responder_if.sv - Avalon-MM link between byte-incrementer master and memory responder
interface amm_mem_responder_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int BE_W   = DATA_W / 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_mem_responder.sv
// rtl/amm_mem_responder.sv - Avalon-MM slave memory with programmable waitrequest and fixed read latency
module amm_mem_responder #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 10,
  parameter int BE_W       = DATA_W / 8,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  amm_mem_responder_if.slave amm,
  input  logic [1:0]        cfg_wait_mode_i,
  input  logic [3:0]        cfg_wait_cycles_i,
  input  logic [15:0]       cfg_lfsr_seed_i,
  input  logic              bd_we_i,
  input  logic [ADDR_W-1:0] bd_addr_i,
  input  logic [DATA_W-1:0] bd_wdata_i,
  output logic [DATA_W-1:0] bd_rdata_o,
  output logic              err_o
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_READY, ST_HOLD} state_t;

  logic [DATA_W-1:0]     mem [DEPTH];
  state_t                state;
  logic [3:0]            hold_cnt;
  logic [15:0]           lfsr;
  logic [15:0]           lfsr_next;
  logic [15:0]           seed;
  logic                  wait_q;
  logic [1:0]            mode;
  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_W-1:0]     rd_word;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [DATA_W-1:0]     pipe_data [RD_LATENCY];

  assign accept    = (amm.read | amm.write) & ~wait_q & ~srst_i;
  assign wr_accept = accept & amm.write;
  assign rd_accept = accept & amm.read & ~amm.write;
  assign mode      = (cfg_wait_mode_i == 2'd3) ? 2'd0 : cfg_wait_mode_i;
  assign seed      = (cfg_lfsr_seed_i == 16'd0) ? 16'hACE1 : cfg_lfsr_seed_i;
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // A read never coincides with an accepted Avalon write, so only the side port can bypass.
  always_comb begin
    rd_word = mem[amm.address];
    if (bd_we_i && (bd_addr_i == amm.address)) begin
      rd_word = bd_wdata_i;
    end
  end

  // Avalon bytes are assigned last so they override the side port on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (bd_we_i) begin
      mem[bd_addr_i] <= bd_wdata_i;
    end
    if (wr_accept) begin
      for (int i = 0; i < BE_W; i++) begin
        if (amm.byteenable[i]) begin
          mem[amm.address][8*i +: 8] <= amm.writedata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      bd_rdata_o <= '0;
    end else begin
      bd_rdata_o <= mem[bd_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state    <= ST_READY;
      hold_cnt <= 4'd0;
      lfsr     <= seed;
      wait_q   <= 1'b1;
    end else begin
      lfsr <= lfsr_next;
      case (mode)
        2'd1: begin
          if (state == ST_HOLD) begin
            if (hold_cnt <= 4'd1) begin
              state  <= ST_READY;
              wait_q <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 4'd1;
              wait_q   <= 1'b1;
            end
          end else if (accept && (cfg_wait_cycles_i != 4'd0)) begin
            state    <= ST_HOLD;
            hold_cnt <= cfg_wait_cycles_i;
            wait_q   <= 1'b1;
          end else begin
            wait_q <= 1'b0;
          end
        end
        2'd2: begin
          state  <= ST_READY;
          wait_q <= lfsr[0];
        end
        default: begin
          state  <= ST_READY;
          wait_q <= 1'b0;
        end
      endcase
    end
  end

  // Data stages only advance behind a valid entry, so the last stage holds the last returned word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pipe_valid <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data[0] <= rd_word;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        if (pipe_valid[k-1]) begin
          pipe_data[k] <= pipe_data[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      err_o <= 1'b0;
    end else if (amm.read && amm.write) begin
      err_o <= 1'b1;
    end
  end

  assign amm.waitrequest   = wait_q;
  assign amm.readdatavalid = pipe_valid[RD_LATENCY-1];
  assign amm.readdata      = pipe_data[RD_LATENCY-1];
endmodule

// File: tb/tb_amm_mem_responder.sv
// tb/tb_amm_mem_responder.sv - two latency variants driven in lockstep against a reference memory model
module tb_amm_mem_responder;
  localparam int DW   = 64;
  localparam int AW   = 10;
  localparam int RL_A = 2;
  localparam int RL_B = 8;

  logic          clk = 1'b0;
  logic          srst;
  logic [1:0]    mode;
  logic [3:0]    ncyc;
  logic [15:0]   seed;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_wdata;
  logic [DW-1:0] bd_rdata_a, bd_rdata_b;
  logic          err_a, err_b;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  amm_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  amm_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  amm_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(RL_A)) dut_a (
    .clk_i(clk), .srst_i(srst), .amm(bus_a),
    .cfg_wait_mode_i(mode), .cfg_wait_cycles_i(ncyc), .cfg_lfsr_seed_i(seed),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata),
    .bd_rdata_o(bd_rdata_a), .err_o(err_a)
  );

  amm_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(RL_B)) dut_b (
    .clk_i(clk), .srst_i(srst), .amm(bus_b),
    .cfg_wait_mode_i(mode), .cfg_wait_cycles_i(ncyc), .cfg_lfsr_seed_i(seed),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata),
    .bd_rdata_o(bd_rdata_b), .err_o(err_b)
  );

  logic [DW-1:0] ref_mem [1 << AW];
  logic          exp_wait, exp_err;
  logic [15:0]   ref_lfsr;
  int            hold_left;
  int            edge_n = 0;
  logic [DW-1:0] exp_bd, last_a, last_b;
  int            due_a[$], due_b[$];
  logic [DW-1:0] dat_a[$], dat_b[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [7:0] be);
    bus_a.read = rd; bus_a.write = wr; bus_a.address = a; bus_a.writedata = d; bus_a.byteenable = be;
    bus_b.read = rd; bus_b.write = wr; bus_b.address = a; bus_b.writedata = d; bus_b.byteenable = be;
  endtask

  task automatic tick(output logic accepted);
    logic          rd, wr, rd_acc, va, vb;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic [1:0]    m;
    logic [3:0]    n;
    rd = bus_a.read; wr = bus_a.write; a = bus_a.address;
    m  = (mode == 2'd3) ? 2'd0 : mode;
    n  = ncyc;
    accepted = (rd || wr) && !exp_wait && !srst;
    exp_bd = srst ? '0 : ref_mem[bd_addr];
    if (rd && wr && !srst) exp_err = 1'b1;
    if (bd_we) ref_mem[bd_addr] = bd_wdata;
    if (accepted && wr) begin
      w = ref_mem[a];
      for (int i = 0; i < DW/8; i++)
        if (bus_a.byteenable[i]) w[8*i +: 8] = bus_a.writedata[8*i +: 8];
      ref_mem[a] = w;
    end
    rd_acc = accepted && rd && !wr;
    @(posedge clk);
    edge_n++;
    if (srst) begin
      exp_wait = 1'b1; exp_err = 1'b0; hold_left = 0;
      ref_lfsr = (seed == 16'd0) ? 16'hACE1 : seed;
      due_a.delete(); dat_a.delete(); due_b.delete(); dat_b.delete();
      last_a = '0; last_b = '0;
    end else begin
      if (rd_acc) begin
        due_a.push_back(edge_n + RL_A - 1); dat_a.push_back(ref_mem[a]);
        due_b.push_back(edge_n + RL_B - 1); dat_b.push_back(ref_mem[a]);
      end
      if (m == 2'd1) begin
        if (hold_left > 0) hold_left--;
        else if (accepted && n != 4'd0) hold_left = int'(n);
        exp_wait = (hold_left > 0);
      end else begin
        hold_left = 0;
        exp_wait  = (m == 2'd2) ? ref_lfsr[0] : 1'b0;
      end
      ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
    end
    @(negedge clk);
    check("waitreq_a", 64'(bus_a.waitrequest), 64'(exp_wait));
    check("waitreq_b", 64'(bus_b.waitrequest), 64'(exp_wait));
    check("err_a", 64'(err_a), 64'(exp_err));
    check("err_b", 64'(err_b), 64'(exp_err));
    check("bd_rdata_a", bd_rdata_a, exp_bd);
    check("bd_rdata_b", bd_rdata_b, exp_bd);
    va = (due_a.size() > 0) && (due_a[0] == edge_n);
    if (va) begin void'(due_a.pop_front()); last_a = dat_a.pop_front(); end
    vb = (due_b.size() > 0) && (due_b[0] == edge_n);
    if (vb) begin void'(due_b.pop_front()); last_b = dat_b.pop_front(); end
    check("rdvalid_a", 64'(bus_a.readdatavalid), 64'(va));
    check("rdvalid_b", 64'(bus_b.readdatavalid), 64'(vb));
    check("rdata_a", bus_a.readdata, last_a);
    check("rdata_b", bus_b.readdata, last_b);
  endtask

  task automatic idle(input int k);
    logic ac;
    drive(1'b0, 1'b0, '0, '0, 8'h00);
    repeat (k) tick(ac);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [7:0] be, output int n);
    logic ac;
    drive(rd, wr, a, d, be);
    n = 0; ac = 1'b0;
    while (!ac && n < 64) begin
      tick(ac);
      n++;
    end
    check("accept_in_bound", 64'(ac), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dummy;
    int   n, span;
    srst = 1'b1; mode = 2'd0; ncyc = 4'd0; seed = 16'h1234;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    drive(1'b0, 1'b0, '0, '0, 8'h00);
    exp_wait = 1'b1; exp_err = 1'b0; ref_lfsr = seed; hold_left = 0;
    last_a = '0; last_b = '0; exp_bd = '0;

    // preload every word so model and DUT memories start identical
    bd_we = 1'b1;
    for (int k = 0; k < (1 << AW); k++) begin
      bd_addr = AW'(k); bd_wdata = {$urandom, $urandom};
      tick(dummy);
    end
    bd_we = 1'b0; bd_addr = '0;
    srst = 1'b0;
    idle(3);

    issue(1'b0, 1'b1, 10'd5, 64'h0102030405060708, 8'hFF, n);
    issue(1'b1, 1'b0, 10'd5, '0, 8'h00, n);
    idle(1);
    check("t1_rdv_lat2", 64'(bus_a.readdatavalid), 64'd1);
    check("t1_data", bus_a.readdata, 64'h0102030405060708);
    idle(8);

    bd_we = 1'b1; bd_addr = 10'd3; bd_wdata = {8{8'hAA}};
    tick(dummy);
    bd_we = 1'b0;
    issue(1'b0, 1'b1, 10'd3, {DW{1'b1}}, 8'h0F, n);
    issue(1'b1, 1'b0, 10'd3, '0, 8'h00, n);
    idle(1);
    check("t2_data", bus_a.readdata, 64'hAAAAAAAA_FFFFFFFF);
    idle(8);

    mode = 2'd1; ncyc = 4'd3; span = 0;
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 1'b0, AW'(k), '0, 8'h00, n);
      span += n;
    end
    idle(12);
    check("t3_span_n3", 64'(span), 64'd13);

    ncyc = 4'd0; span = 0;
    for (int k = 4; k < 8; k++) begin
      issue(1'b1, 1'b0, AW'(k), '0, 8'h00, n);
      span += n;
    end
    idle(10);
    check("t3_span_n0", 64'(span), 64'd4);

    mode = 2'd3; ncyc = 4'd5; span = 0;
    idle(1);
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 1'b1, AW'(k + 8), {$urandom, $urandom}, 8'($urandom), n);
      span += n;
    end
    idle(2);
    check("t3_span_mode3", 64'(span), 64'd4);

    mode = 2'd2; seed = 16'h1234; srst = 1'b1;
    idle(2);
    srst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      bd_we    = ($urandom_range(0, 7) == 0);
      bd_addr  = AW'($urandom_range(0, 15));
      bd_wdata = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        issue(1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, 8'h00, n);
      else
        issue(1'b0, 1'b1, AW'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom), n);
      if ($urandom_range(0, 3) == 0) begin
        bd_we = 1'b0;
        idle(1);
      end
    end
    bd_we = 1'b0;
    idle(12);

    seed = 16'h0000; srst = 1'b1;
    idle(1);
    srst = 1'b0;
    idle(24);

    mode = 2'd0; seed = 16'h1234;
    idle(2);
    for (int k = 0; k < 8; k++) issue(1'b1, 1'b0, AW'(k), '0, 8'h00, n);
    idle(2);
    srst = 1'b1;
    tick(dummy);
    srst = 1'b0;
    idle(12);
    for (int k = 0; k < 8; k++) begin
      bd_addr = AW'(k);
      tick(dummy);
      check("t5_bd_intact", bd_rdata_b, ref_mem[k]);
    end

    issue(1'b1, 1'b1, 10'd7, 64'hDEADBEEF_CAFEF00D, 8'hFF, n);
    idle(1);
    check("t6_err_set", 64'(err_a), 64'd1);
    issue(1'b1, 1'b0, 10'd7, '0, 8'h00, n);
    idle(1);
    check("t6_write_done", bus_a.readdata, 64'hDEADBEEF_CAFEF00D);
    idle(10);
    check("t6_err_sticky", 64'(err_b), 64'd1);
    srst = 1'b1;
    tick(dummy);
    srst = 1'b0;
    idle(1);
    check("t6_err_clear", 64'(err_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
